// File: rtl/writeback.sv
// Retire stage: latches one execute result, then commits opnd0, opnd1 and EFLAGS in order.
// Owns the architectural EFLAGS register and the retired-instruction counter.
module writeback #(
    parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      opnd0_w,
    input  logic [31:0]      opnd1_w,
    input  logic [31:0]      eflags_in,
    input  logic             eflags_wr,
    input  logic [1:0]       dst0_kind,
    input  logic [2:0]       dst0_reg,
    input  logic [31:0]      dst0_addr,
    input  logic [1:0]       dst1_kind,
    input  logic [2:0]       dst1_reg,
    input  logic [31:0]      dst1_addr,
    input  logic [1:0]       opsize,
    output logic             reg_wr_en,
    output logic [2:0]       reg_wr_idx,
    output logic [31:0]      reg_wr_data,
    output logic [3:0]       reg_wr_mask,
    output logic             mem_wr_req,
    output logic [31:0]      mem_wr_addr,
    output logic [31:0]      mem_wr_data,
    output logic [3:0]       mem_wr_mask,
    input  logic             mem_wr_ack,
    output logic [31:0]      eflags,
    output logic             retire,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [1:0] {IDLE, WR0, WR1, RET} state_t;

    localparam logic [1:0] K_REG = 2'b01;
    localparam logic [1:0] K_MEM = 2'b10;

    state_t           state_q, state_d;
    logic [31:0]      opnd0_q, opnd1_q, addr0_q, addr1_q, efl_in_q;
    logic [1:0]       kind0_q, kind1_q, opsize_q;
    logic [2:0]       reg0_q, reg1_q;
    logic             efl_wr_q;
    logic [31:0]      eflags_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       cur_kind;
    logic [2:0]       cur_reg;
    logic [31:0]      cur_addr, cur_data, data_lane;
    logic [3:0]       size_mask;
    logic             high_byte, active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opnd0_q  <= '0;
            opnd1_q  <= '0;
            addr0_q  <= '0;
            addr1_q  <= '0;
            efl_in_q <= '0;
            kind0_q  <= '0;
            kind1_q  <= '0;
            opsize_q <= '0;
            reg0_q   <= '0;
            reg1_q   <= '0;
            efl_wr_q <= 1'b0;
            eflags_q <= EFLAGS_RESET;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                opnd0_q  <= opnd0_w;
                opnd1_q  <= opnd1_w;
                addr0_q  <= dst0_addr;
                addr1_q  <= dst1_addr;
                efl_in_q <= eflags_in;
                kind0_q  <= dst0_kind;
                kind1_q  <= dst1_kind;
                opsize_q <= opsize;
                reg0_q   <= dst0_reg;
                reg1_q   <= dst1_reg;
                efl_wr_q <= eflags_wr;
            end
            if (state_q == RET) begin
                if (efl_wr_q) eflags_q <= efl_in_q;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Write port fields come from whichever destination the FSM is currently committing.
    always_comb begin
        cur_kind  = kind0_q;
        cur_reg   = reg0_q;
        cur_addr  = addr0_q;
        cur_data  = opnd0_q;
        if (state_q == WR1) begin
            cur_kind = kind1_q;
            cur_reg  = reg1_q;
            cur_addr = addr1_q;
            cur_data = opnd1_q;
        end

        size_mask = 4'b1111;
        if (opsize_q == 2'b00)      size_mask = 4'b0001;
        else if (opsize_q == 2'b01) size_mask = 4'b0011;
        data_lane = cur_data & {{8{size_mask[3]}}, {8{size_mask[2]}},
                                {8{size_mask[1]}}, {8{size_mask[0]}}};

        // 8-bit indices 4-7 name AH/CH/DH/BH: byte 1 of GPR 0-3.
        high_byte   = (opsize_q == 2'b00) && cur_reg[2];
        reg_wr_idx  = high_byte ? {1'b0, cur_reg[1:0]} : cur_reg;
        reg_wr_mask = high_byte ? 4'b0010 : size_mask;
        reg_wr_data = high_byte ? {16'h0000, cur_data[7:0], 8'h00} : data_lane;

        mem_wr_addr = cur_addr;
        mem_wr_data = data_lane;
        mem_wr_mask = size_mask;

        active      = (state_q == WR0) || (state_q == WR1);
        reg_wr_en   = active && (cur_kind == K_REG);
        mem_wr_req  = active && (cur_kind == K_MEM);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = WR0;
            WR0:  if (!(mem_wr_req && !mem_wr_ack)) state_d = WR1;
            WR1:  if (!(mem_wr_req && !mem_wr_ack)) state_d = RET;
            RET:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign retire        = (state_q == RET);
    assign eflags        = eflags_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback.sv
// Randomized and directed bench for writeback against a queue-of-commit-steps reference model.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opnd0_w, opnd1_w, eflags_in, dst0_addr, dst1_addr;
    logic        eflags_wr;
    logic [1:0]  dst0_kind, dst1_kind, opsize;
    logic [2:0]  dst0_reg, dst1_reg;
    logic        reg_wr_en, mem_wr_req, mem_wr_ack, retire;
    logic [2:0]  reg_wr_idx;
    logic [31:0] reg_wr_data, mem_wr_addr, mem_wr_data, eflags, retired_count;
    logic [3:0]  reg_wr_mask, mem_wr_mask;

    int n_pass = 0;
    int n_total = 0;

    writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opnd0_w(opnd0_w), .opnd1_w(opnd1_w), .eflags_in(eflags_in), .eflags_wr(eflags_wr),
        .dst0_kind(dst0_kind), .dst0_reg(dst0_reg), .dst0_addr(dst0_addr),
        .dst1_kind(dst1_kind), .dst1_reg(dst1_reg), .dst1_addr(dst1_addr),
        .opsize(opsize),
        .reg_wr_en(reg_wr_en), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
        .reg_wr_mask(reg_wr_mask),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_mask(mem_wr_mask), .mem_wr_ack(mem_wr_ack),
        .eflags(eflags), .retire(retire), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: each accepted instruction becomes a list of commit steps
    // (kind 0 none, 1 reg, 2 mem, 3 retire); the head step is what the outputs show.
    typedef struct {
        int          kind;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        efw;
    } step_t;

    step_t       q[$];
    logic [31:0] m_eflags;
    int unsigned m_count;

    function automatic step_t mk(input logic [1:0] k, input logic [2:0] r, input logic [31:0] a,
                                 input logic [31:0] d, input logic [1:0] sz);
        step_t s;
        int nb;
        nb     = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        s.kind = (k == 1) ? 1 : (k == 2) ? 2 : 0;
        s.idx  = r;
        s.data = d;
        s.addr = a;
        s.mask = 4'((1 << nb) - 1);
        s.efw  = 1'b0;
        if (s.kind == 1 && sz == 0 && r >= 4) begin
            s.idx  = 3'(r - 4);
            s.mask = 4'b0010;
            s.data = (d & 32'hFF) << 8;
        end
        return s;
    endfunction

    function automatic logic [31:0] bm(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_eflags = 32'h0000_0002;
            m_count  = 0;
        end else if (q.size() != 0) begin
            if (!(q[0].kind == 2 && !mem_wr_ack)) begin
                if (q[0].kind == 3) begin
                    if (q[0].efw) m_eflags = q[0].data;
                    m_count++;
                end
                void'(q.pop_front());
            end
        end else if (in_valid) begin
            step_t r;
            q.push_back(mk(dst0_kind, dst0_reg, dst0_addr, opnd0_w, opsize));
            q.push_back(mk(dst1_kind, dst1_reg, dst1_addr, opnd1_w, opsize));
            r = '{kind: 3, idx: 3'd0, data: eflags_in, addr: 32'd0, mask: 4'd0, efw: eflags_wr};
            q.push_back(r);
        end
    end

    always @(negedge clk) begin
        int k;
        k = (q.size() == 0) ? -1 : q[0].kind;
        chk("in_ready", 32'(in_ready), 32'(k == -1));
        chk("reg_wr_en", 32'(reg_wr_en), 32'(k == 1));
        chk("mem_wr_req", 32'(mem_wr_req), 32'(k == 2));
        chk("retire", 32'(retire), 32'(k == 3));
        chk("eflags", eflags, m_eflags);
        chk("retired_count", retired_count, m_count);
        if (k == 1) begin
            chk("reg_idx", 32'(reg_wr_idx), 32'(q[0].idx));
            chk("reg_mask", 32'(reg_wr_mask), 32'(q[0].mask));
            chk("reg_data", reg_wr_data & bm(q[0].mask), q[0].data & bm(q[0].mask));
        end
        if (k == 2) begin
            chk("mem_addr", mem_wr_addr, q[0].addr);
            chk("mem_mask", 32'(mem_wr_mask), 32'(q[0].mask));
            chk("mem_data", mem_wr_data & bm(q[0].mask), q[0].data & bm(q[0].mask));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] k0, input logic [2:0] r0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic [1:0] k1, input logic [2:0] r1,
                         input logic [31:0] a1, input logic [31:0] d1, input logic [1:0] sz,
                         input logic efw, input logic [31:0] efi);
        in_valid  = 1'b1;
        dst0_kind = k0; dst0_reg = r0; dst0_addr = a0; opnd0_w = d0;
        dst1_kind = k1; dst1_reg = r1; dst1_addr = a1; opnd1_w = d1;
        opsize    = sz; eflags_wr = efw; eflags_in = efi;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lo_rdy, n_ret;
        rst = 1'b1; in_valid = 1'b0; mem_wr_ack = 1'b0;
        drive(2'd0, 3'd0, 32'd0, 32'd0, 2'd0, 3'd0, 32'd0, 32'd0, 2'd2, 1'b0, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_eflags", eflags, 32'h0000_0002);
        chk("rst_count", retired_count, 32'd0);
        chk("rst_strobes", {29'd0, reg_wr_en, mem_wr_req, retire}, 32'd0);
        rst = 1'b0;
        step();

        // ALU op to EBX with EFLAGS update
        drive(2'b01, 3'd3, 32'd0, 32'hDEAD_BEEF, 2'b00, 3'd0, 32'd0, 32'd0, 2'b10, 1'b1, 32'h846);
        step();
        in_valid = 1'b0;
        chk("t1_en", 32'(reg_wr_en), 32'd1);
        chk("t1_idx", 32'(reg_wr_idx), 32'd3);
        chk("t1_mask", 32'(reg_wr_mask), 32'hF);
        chk("t1_data", reg_wr_data, 32'hDEAD_BEEF);
        step(); step();
        chk("t1_retire", 32'(retire), 32'd1);
        chk("t1_eflags_old", eflags, 32'h0000_0002);
        step();
        chk("t1_eflags_new", eflags, 32'h0000_0846);
        chk("t1_count", retired_count, 32'd1);

        // 8-bit write to CH
        drive(2'b01, 3'd5, 32'd0, 32'h0000_00A5, 2'b00, 3'd0, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);
        step();
        in_valid = 1'b0;
        chk("t2_idx", 32'(reg_wr_idx), 32'd1);
        chk("t2_mask", 32'(reg_wr_mask), 32'h2);
        chk("t2_data", reg_wr_data, 32'h0000_A500);
        step(); step(); step();

        // XCHG-style two register writes
        drive(2'b01, 3'd0, 32'd0, 32'd1, 2'b01, 3'd2, 32'd0, 32'd2, 2'b10, 1'b0, 32'hFFFF);
        step();
        in_valid = 1'b0;
        chk("t3_idx0", 32'(reg_wr_idx), 32'd0);
        chk("t3_data0", reg_wr_data, 32'd1);
        step();
        chk("t3_en1", 32'(reg_wr_en), 32'd1);
        chk("t3_idx1", 32'(reg_wr_idx), 32'd2);
        chk("t3_data1", reg_wr_data, 32'd2);
        step(); step();
        chk("t3_eflags", eflags, 32'h0000_0846);

        // 16-bit memory store, ack arrives in the 4th request cycle
        drive(2'b10, 3'd0, 32'h1000, 32'h1234_5678, 2'b00, 3'd0, 32'd0, 32'd0, 2'b01, 1'b0, 32'd0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_req", 32'(mem_wr_req), 32'd1);
            chk("t4_mask", 32'(mem_wr_mask), 32'h3);
            chk("t4_addr", mem_wr_addr, 32'h1000);
            mem_wr_ack = (i == 3);
            step();
        end
        mem_wr_ack = 1'b0;
        chk("t4_req_drop", 32'(mem_wr_req), 32'd0);
        chk("t4_no_retire_wr1", 32'(retire), 32'd0);
        step();
        chk("t4_retire", 32'(retire), 32'd1);
        step();
        chk("t4_count", retired_count, 32'd4);

        // Reset in the middle of a memory stall
        drive(2'b10, 3'd0, 32'h2000, 32'hCAFE_F00D, 2'b01, 3'd1, 32'd0, 32'd7, 2'b10, 1'b1, 32'h8D5);
        step();
        in_valid = 1'b0;
        step();
        chk("t5_req_before", 32'(mem_wr_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_req", 32'(mem_wr_req), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_eflags", eflags, 32'h0000_0002);
        chk("t5_count", retired_count, 32'd0);
        chk("t5_retire", 32'(retire), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_ret = 0;
        for (int i = 0; i < 4; i++) begin step(); n_ret += int'(retire); end
        chk("t5_no_retire", 32'(n_ret), 32'd0);

        // in_valid held for 8 cycles, no destinations
        drive(2'b00, 3'd0, 32'd0, 32'd0, 2'b11, 3'd0, 32'd0, 32'd0, 2'b10, 1'b0, 32'd0);
        lo_rdy = 0; n_ret = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) lo_rdy += int'(!in_ready);
            n_ret += int'(retire);
            if (i == 7) in_valid = 1'b0;
            step();
        end
        chk("t6_retires", 32'(n_ret), 32'd2);
        chk("t6_ready_low", 32'(lo_rdy), 32'd6);
        chk("t6_count", retired_count, 32'd2);

        // Randomized traffic with random memory back-pressure
        for (int i = 0; i < 600; i++) begin
            drive(2'($urandom_range(0, 3)), 3'($urandom), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 3'($urandom), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom), $urandom);
            in_valid   = ($urandom_range(0, 9) < 7);
            mem_wr_ack = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
